// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer: streams R,G,B words from the frame store to rgb2gray one pixel
// per three cycles and writes the returned grayscale results to the output buffer.
module rgb2gray_frame_ctrl #(
   parameter int unsigned NUM_PIXELS    = 4096,
   parameter int unsigned ADDR_W        = 14,
   parameter int unsigned OUT_ADDR_W    = 12,
   parameter int unsigned DRAIN_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  abort_i,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic                  mem_rd_o,
   input  logic [15:0]           mem_data_i,
   output logic [7:0]            red_o,
   output logic [7:0]            green_o,
   output logic [7:0]            blue_o,
   output logic                  conv_valid_o,
   input  logic [7:0]            gray_i,
   input  logic                  gray_valid_i,
   output logic [OUT_ADDR_W-1:0] out_addr_o,
   output logic [7:0]            out_data_o,
   output logic                  out_we_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic                  error_o,
   output logic [OUT_ADDR_W:0]   pix_count_o
);

   localparam int unsigned          DRAIN_W     = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0]    LAST_ADDR   = ADDR_W'(3 * NUM_PIXELS - 1);
   localparam logic [OUT_ADDR_W:0]  PIX_FULL    = (OUT_ADDR_W + 1)'(NUM_PIXELS);
   localparam logic [DRAIN_W-1:0]   DRAIN_LIMIT = DRAIN_W'(DRAIN_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;

   logic                   start_ok;
   logic                   active;
   logic                   last_issue;
   logic                   res_accept;
   logic                   complete;
   logic                   timeout;

   logic [ADDR_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic                   rtn_valid_q;
   logic [1:0]             rtn_phase_q;
   logic [7:0]             red_q, green_q, blue_q;
   logic                   conv_valid_q;
   logic [OUT_ADDR_W:0]    pix_cnt_q, pix_cnt_d;
   logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic [OUT_ADDR_W-1:0]  out_addr_q;
   logic [7:0]             out_data_q;
   logic                   out_we_q;
   logic                   error_q;

   logic [7:0]             unused_mem_hi;
   assign unused_mem_hi = mem_data_i[15:8];

   always_comb begin
      start_ok   = (state_q == IDLE) && start_i;
      active     = (state_q == READ) || (state_q == DRAIN);
      last_issue = (state_q == READ) && (rd_cnt_q == LAST_ADDR);
      res_accept = active && gray_valid_i && !abort_i && (pix_cnt_q != PIX_FULL);

      rd_cnt_d = rd_cnt_q;
      if (start_ok) begin
         rd_cnt_d = '0;
      end else if ((state_q == READ) && !abort_i && !last_issue) begin
         rd_cnt_d = rd_cnt_q + ADDR_W'(1);
      end

      pix_cnt_d = pix_cnt_q;
      if (start_ok) begin
         pix_cnt_d = '0;
      end else if (res_accept) begin
         pix_cnt_d = pix_cnt_q + (OUT_ADDR_W + 1)'(1);
      end

      // A result landing in the same cycle counts, so completion beats timeout
      complete = (state_q == DRAIN) && (pix_cnt_d == PIX_FULL);

      drain_cnt_d = drain_cnt_q;
      if (start_ok) begin
         drain_cnt_d = '0;
      end else if ((state_q == DRAIN) && !complete) begin
         drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
      end

      timeout = (state_q == DRAIN) && !complete && !abort_i && (drain_cnt_d == DRAIN_LIMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = READ;
         end
         READ: begin
            if (abort_i)         state_d = IDLE;
            else if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (abort_i)       state_d = IDLE;
            else if (complete) state_d = DONE;
            else if (timeout)  state_d = IDLE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      mem_rd_o     = 1'b0;
      busy_o       = 1'b0;
      frame_done_o = 1'b0;
      unique case (state_q)
         IDLE: begin
         end
         READ: begin
            mem_rd_o = 1'b1;
            busy_o   = 1'b1;
         end
         DRAIN: begin
            busy_o = 1'b1;
         end
         DONE: begin
            frame_done_o = !abort_i;
         end
         default: begin
         end
      endcase
   end

   // Returned words are tagged by rtn_phase_q: 0 red, 1 green, 2 blue + beat.
   // The write address is the saturating result count, so it can never wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt_q     <= '0;
         rtn_valid_q  <= 1'b0;
         rtn_phase_q  <= '0;
         red_q        <= '0;
         green_q      <= '0;
         blue_q       <= '0;
         conv_valid_q <= 1'b0;
         pix_cnt_q    <= '0;
         drain_cnt_q  <= '0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_we_q     <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         rd_cnt_q     <= rd_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         conv_valid_q <= 1'b0;
         out_we_q     <= 1'b0;
         rtn_valid_q  <= (state_q == READ) && !abort_i;

         if (start_ok) begin
            rtn_phase_q <= '0;
         end else if (rtn_valid_q && !abort_i) begin
            unique case (rtn_phase_q)
               2'd0: begin
                  red_q       <= mem_data_i[7:0];
                  rtn_phase_q <= 2'd1;
               end
               2'd1: begin
                  green_q     <= mem_data_i[7:0];
                  rtn_phase_q <= 2'd2;
               end
               default: begin
                  blue_q       <= mem_data_i[7:0];
                  conv_valid_q <= 1'b1;
                  rtn_phase_q  <= 2'd0;
               end
            endcase
         end

         if (res_accept) begin
            out_we_q   <= 1'b1;
            out_data_q <= gray_i;
            out_addr_q <= pix_cnt_q[OUT_ADDR_W-1:0];
         end

         if (start_ok) begin
            error_q <= 1'b0;
         end else if (timeout) begin
            error_q <= 1'b1;
         end
      end
   end

   assign mem_addr_o   = rd_cnt_q;
   assign red_o        = red_q;
   assign green_o      = green_q;
   assign blue_o       = blue_q;
   assign conv_valid_o = conv_valid_q;
   assign out_addr_o   = out_addr_q;
   assign out_data_o   = out_data_q;
   assign out_we_o     = out_we_q;
   assign error_o      = error_q;
   assign pix_count_o  = pix_cnt_q;

endmodule

// File: doc/rgb2gray_frame_ctrl.md
Name: rgb2gray_frame_ctrl

Overview:
Frame sequencer for the rgb2gray converter. On a start pulse it walks a 16-bit-word frame memory holding R,G,B words per pixel in sequence. It presents each pixel to the converter as a single valid beat, collects the converter's grayscale results into an output buffer, and signals frame completion. It sits between the frame store, rgb2gray, and the grayscale store.

Parameters:
NUM_PIXELS, 4096, pixels per frame; frame memory holds 3*NUM_PIXELS words
ADDR_W, 14, frame memory address width (must cover 3*NUM_PIXELS-1)
OUT_ADDR_W, 12, output buffer address width (must cover NUM_PIXELS-1)
DRAIN_TIMEOUT, 64, max cycles to wait for outstanding results after the last issue

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle pulse; begins a frame when idle
abort_i  in  1  synchronous abort; returns to IDLE
mem_addr_o  out  ADDR_W  frame memory read address
mem_rd_o  out  1  frame memory read enable
mem_data_i  in  16  read data, valid exactly 1 cycle after mem_rd_o; only [7:0] used
red_o/green_o/blue_o  out  8 each  pixel to converter (red_i/green_i/blue_i)
conv_valid_o  out  1  pixel valid to converter (done_i)
gray_i  in  8  converter result (grayscale_o)
gray_valid_i  in  1  converter result valid (done_o)
out_addr_o  out  OUT_ADDR_W  output buffer write address
out_data_o  out  8  output buffer write data
out_we_o  out  1  output buffer write enable
busy_o  out  1  high from accepted start until frame_done/abort/error
frame_done_o  out  1  one-cycle pulse when all NUM_PIXELS results are written
error_o  out  1  sticky drain-timeout flag; cleared by next accepted start or reset
pix_count_o  out  OUT_ADDR_W+1  results written this frame

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, counters 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start_i=1 -> READ next cycle; clears error_o, pix_count_o, and the read/write counters. start_i while not IDLE is ignored.
- READ: issues one read per cycle, mem_rd_o=1, with addresses 0,1,2,...,3*NUM_PIXELS-1 consecutive.
- Data returning for address 3p is registered to red_o, and 3p+1 to green_o.
- On the cycle data for 3p+2 returns, blue_o=mem_data_i[7:0] (registered), red_o/green_o are held, and conv_valid_o=1 for exactly one cycle.
- First conv_valid_o occurs 4 cycles after the first mem_rd_o cycle. Throughput is one pixel per 3 cycles. R/G/B are stable while conv_valid_o=1.
- After issuing address 3*NUM_PIXELS-1: mem_rd_o=0 and the FSM goes to DRAIN. The final conv_valid_o still fires, one cycle later.
- Result path, active in READ and DRAIN: each gray_valid_i=1 gives out_we_o=1, out_data_o=gray_i, out_addr_o=write counter, all registered with 1-cycle latency. The write counter then increments and pix_count_o increments.
- gray_valid_i is ignored in IDLE/DONE and once pix_count_o reaches NUM_PIXELS (no write, no wrap).
- DRAIN: if pix_count_o==NUM_PIXELS -> DONE. Otherwise the drain counter increments. If it reaches DRAIN_TIMEOUT: error_o=1, busy_o=0, go to IDLE with no frame_done_o.
- Simultaneous last write and drain check: completion takes priority over timeout.
- DONE: frame_done_o=1 for one cycle, busy_o=0 -> IDLE.
- abort_i in READ/DRAIN/DONE -> IDLE next cycle. It clears mem_rd_o, conv_valid_o, out_we_o and busy_o. No frame_done_o. pix_count_o holds its value. abort_i in IDLE has no effect.
- start_i and abort_i in the same IDLE cycle: abort has no effect, start is accepted.
- Reset mid-frame: immediate return to reset values; no partial pulses after release.
- Address counters never wrap within a frame; both restart at 0 each accepted start.

Test Plan:
- NUM_PIXELS=4, mem words 0x10..0x1B, converter model gray=(r+g+b)/3 with 1-cycle latency, start pulse. Required: conv_valid_o beats with (10,11,12),(13,14,15),(16,17,18),(19,1A,1B) spaced 3 cycles apart, first beat 4 cycles after the first read. Out buffer holds 11,14,17,1A at addresses 0..3. frame_done_o pulses once; pix_count_o=4.
- start_i repeated every cycle during the frame: only the first start is accepted; addresses are not restarted; exactly one frame_done_o.
- Converter model drops the final result, DRAIN_TIMEOUT=8: error_o=1 exactly 8 cycles into DRAIN, no frame_done_o, busy_o=0. A following start clears error_o.
- abort_i asserted on the 5th read cycle: next cycle mem_rd_o=0 and busy_o=0; no further conv_valid_o or out_we_o. A new start re-reads from address 0.
- rst pulled low mid-DRAIN: all outputs go to 0 asynchronously (before next clk edge); after release the block stays idle until start.
- Spurious gray_valid_i in IDLE and a 5th gray_valid_i after 4 results (NUM_PIXELS=4): no out_we_o, pix_count_o stays at 4.
